// File: rtl/exec_unit_pkg.sv
// Shared constants for the exec_unit slice: field sizes, opcodes, ALU operations
// and the control-state enum.
package exec_unit_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int BYTE_SIZE_DEF = 8;
  localparam int NIB_SIZE_DEF  = 4;

  // Opcodes with bit 3 clear; bit 3 set selects the ALU class
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOADLO = 4'h1;
  localparam logic [3:0] OP_IN     = 4'h2;
  localparam logic [3:0] OP_OUT    = 4'h3;
  localparam logic [3:0] OP_JMP    = 4'h4;
  localparam logic [3:0] OP_BR     = 4'h5;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_NOT = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_REGLOAD  = 3'd1,
    ST_ALUOP    = 3'd2,
    ST_MEMLOAD  = 3'd3,
    ST_MEMSTORE = 3'd4,
    ST_REGSTORE = 3'd5,
    ST_NEXT     = 3'd6
  } ctrl_state_e;

endpackage

// File: rtl/exec_unit_if.sv
// Bundle of decode outputs, phase strobes and datapath values between exec_unit
// and the rest of the core; state is a debug view of the control sequencer.
interface exec_unit_if #(
  parameter int WORD_SIZE = exec_unit_pkg::WORD_SIZE_DEF,
  parameter int BYTE_SIZE = exec_unit_pkg::BYTE_SIZE_DEF,
  parameter int NIB_SIZE  = exec_unit_pkg::NIB_SIZE_DEF
);
  // No valid/ready handshake: each do_* strobe is a one-cycle qualifier, at most one high per cycle.
  logic [WORD_SIZE-1:0]       instr;
  logic [WORD_SIZE-1:0]       regval1;
  logic [WORD_SIZE-1:0]       regval2;
  logic [WORD_SIZE-1:0]       portin;
  logic [NIB_SIZE-1:0]        opcode;
  logic [NIB_SIZE-1:0]        reg1;
  logic [NIB_SIZE-1:0]        reg2;
  logic [NIB_SIZE-1:0]        reg3;
  logic [NIB_SIZE-1:0]        smallval;
  logic [BYTE_SIZE-1:0]       bigval;
  logic                       isaluop;
  logic [2:0]                 aluop;
  logic                       do_fetch;
  logic                       do_regload;
  logic                       do_aluop;
  logic                       do_memload;
  logic                       do_memstore;
  logic                       do_regstore;
  logic                       do_next;
  logic [WORD_SIZE-1:0]       aluout;
  logic [WORD_SIZE-1:0]       storeval;
  logic [WORD_SIZE-1:0]       pointer_adj;
  exec_unit_pkg::ctrl_state_e state;

  modport slave (
    input  instr, regval1, regval2, portin,
    output opcode, reg1, reg2, reg3, smallval, bigval, isaluop, aluop,
    output do_fetch, do_regload, do_aluop, do_memload, do_memstore, do_regstore, do_next,
    output aluout, storeval, pointer_adj, state
  );

  modport master (
    output instr, regval1, regval2, portin,
    input  opcode, reg1, reg2, reg3, smallval, bigval, isaluop, aluop,
    input  do_fetch, do_regload, do_aluop, do_memload, do_memstore, do_regstore, do_next,
    input  aluout, storeval, pointer_adj, state
  );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU for exec_unit: eight operations on two WIDTH-bit operands,
// shifts take their amount from the low SHAMT_W bits of in2.
module exec_alu
  import exec_unit_pkg::*;
#(
  parameter int WIDTH   = WORD_SIZE_DEF,
  parameter int SHAMT_W = NIB_SIZE_DEF
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = in1_i + in2_i;
      ALU_SUB: result_o = in1_i - in2_i;
      ALU_AND: result_o = in1_i & in2_i;
      ALU_OR:  result_o = in1_i | in2_i;
      ALU_XOR: result_o = in1_i ^ in2_i;
      ALU_SHL: result_o = in1_i << in2_i[SHAMT_W-1:0];
      ALU_SHR: result_o = in1_i >> in2_i[SHAMT_W-1:0];
      ALU_NOT: result_o = ~in1_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Instruction decode and seven-phase control sequencer with registered ALU result.
// Build option: define EXEC_BRANCH_EN to enable conditional branch (BR); otherwise BR is a NOP.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int BYTE_SIZE = BYTE_SIZE_DEF,
  parameter int NIB_SIZE  = NIB_SIZE_DEF
) (
  input  logic       clk,
  input  logic       do_reset,
  exec_unit_if.slave bus
);

  logic [NIB_SIZE-1:0]  opcode;
  logic [BYTE_SIZE-1:0] bigval;
  logic                 isaluop;
  logic [WORD_SIZE-1:0] alu_result;
  logic [WORD_SIZE-1:0] aluout_q;
  logic [WORD_SIZE-1:0] bigval_sext;
  logic [WORD_SIZE-1:0] bigval_zext;
  logic [WORD_SIZE-1:0] one_word;
  logic                 branch_taken;
  logic                 writes_reg;
  ctrl_state_e          state_q, state_d;
  logic                 fetch, regload, aluop_en, memload, memstore, regstore, next;

  assign opcode  = bus.instr[4*NIB_SIZE-1 -: NIB_SIZE];
  assign bigval  = bus.instr[BYTE_SIZE-1:0];
  assign isaluop = opcode[NIB_SIZE-1];

  assign bus.opcode   = opcode;
  assign bus.reg1     = bus.instr[3*NIB_SIZE-1 -: NIB_SIZE];
  assign bus.reg2     = bus.instr[2*NIB_SIZE-1 -: NIB_SIZE];
  assign bus.reg3     = bus.instr[NIB_SIZE-1:0];
  assign bus.smallval = bus.instr[NIB_SIZE-1:0];
  assign bus.bigval   = bigval;
  assign bus.isaluop  = isaluop;
  assign bus.aluop    = opcode[2:0];

  exec_alu #(
    .WIDTH   (WORD_SIZE),
    .SHAMT_W (NIB_SIZE)
  ) u_alu (
    .op_i     (opcode[2:0]),
    .in1_i    (bus.regval1),
    .in2_i    (bus.regval2),
    .result_o (alu_result)
  );

  assign writes_reg = isaluop || (opcode == OP_LOADLO) || (opcode == OP_IN);

  always_ff @(posedge clk) begin
    if (do_reset) begin
      state_q  <= ST_FETCH;
      aluout_q <= '0;
    end else begin
      state_q <= state_d;
      if (aluop_en) aluout_q <= alu_result;
    end
  end

  // Every phase occupies one cycle whether or not its strobe qualifies; reset silences all strobes.
  always_comb begin
    state_d  = state_q;
    fetch    = 1'b0;
    regload  = 1'b0;
    aluop_en = 1'b0;
    memload  = 1'b0;
    memstore = 1'b0;
    regstore = 1'b0;
    next     = 1'b0;
    if (!do_reset) begin
      case (state_q)
        ST_FETCH:    begin fetch    = 1'b1;                 state_d = ST_REGLOAD;  end
        ST_REGLOAD:  begin regload  = 1'b1;                 state_d = ST_ALUOP;    end
        ST_ALUOP:    begin aluop_en = isaluop;              state_d = ST_MEMLOAD;  end
        ST_MEMLOAD:  begin memload  = (opcode == OP_IN);    state_d = ST_MEMSTORE; end
        ST_MEMSTORE: begin memstore = (opcode == OP_OUT);   state_d = ST_REGSTORE; end
        ST_REGSTORE: begin regstore = writes_reg;           state_d = ST_NEXT;     end
        ST_NEXT:     begin next     = 1'b1;                 state_d = ST_FETCH;    end
        default:     begin                                  state_d = ST_FETCH;    end
      endcase
    end
  end

  assign bus.do_fetch    = fetch;
  assign bus.do_regload  = regload;
  assign bus.do_aluop    = aluop_en;
  assign bus.do_memload  = memload;
  assign bus.do_memstore = memstore;
  assign bus.do_regstore = regstore;
  assign bus.do_next     = next;
  assign bus.aluout      = aluout_q;
  assign bus.state       = state_q;

`ifdef EXEC_BRANCH_EN
  assign branch_taken = (opcode == OP_BR) && (bus.regval1 != '0);
`else
  assign branch_taken = 1'b0;
`endif

  assign bigval_sext = {{(WORD_SIZE-BYTE_SIZE){bigval[BYTE_SIZE-1]}}, bigval};
  assign bigval_zext = {{(WORD_SIZE-BYTE_SIZE){1'b0}}, bigval};
  assign one_word    = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  assign bus.pointer_adj = ((opcode == OP_JMP) || branch_taken) ? bigval_sext : one_word;

  always_comb begin
    bus.storeval = aluout_q;
    if (opcode == OP_LOADLO)  bus.storeval = bigval_zext;
    else if (opcode == OP_IN) bus.storeval = bus.portin;
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: per-cycle compare against a phase-counter model
// plus directed instructions with hand-computed expectations.
module tb_exec_unit;
  import exec_unit_pkg::*;

  logic clk = 1'b0;
  logic do_reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  exec_unit_if bus ();

  exec_unit dut (
    .clk      (clk),
    .do_reset (do_reset),
    .bus      (bus)
  );

  // strobe vector: bit0 fetch .. bit6 next, in phase order
  logic [6:0] strobes;
  assign strobes = {bus.do_next, bus.do_regstore, bus.do_memstore, bus.do_memload,
                    bus.do_aluop, bus.do_regload, bus.do_fetch};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[3:0];
      3'd6: return a >> b[3:0];
      default: return ~a;
    endcase
  endfunction

  function automatic logic [6:0] exp_strobes(input int phase, input logic [15:0] ins, input logic rst);
    logic [3:0] op;
    logic       qual;
    op = ins[15:12];
    if (rst) return 7'd0;
    case (phase)
      2:       qual = ins[15];
      3:       qual = (op == 4'd2);
      4:       qual = (op == 4'd3);
      5:       qual = ins[15] || op == 4'd1 || op == 4'd2;
      default: qual = 1'b1;
    endcase
    return qual ? (7'd1 << phase) : 7'd0;
  endfunction

  function automatic logic [15:0] exp_ptr(input logic [15:0] ins, input logic [15:0] r1);
    logic [15:0] sx;
    sx = {{8{ins[7]}}, ins[7:0]};
    if (ins[15:12] == 4'd4) return sx;
`ifdef EXEC_BRANCH_EN
    if (ins[15:12] == 4'd5 && r1 != 16'd0) return sx;
`else
    if (r1 === 16'hxxxx) return 16'hxxxx;
`endif
    return 16'd1;
  endfunction

  function automatic logic [15:0] exp_store(input logic [15:0] ins, input logic [15:0] pin,
                                            input logic [15:0] alu);
    if (ins[15:12] == 4'd1) return {8'h00, ins[7:0]};
    if (ins[15:12] == 4'd2) return pin;
    return alu;
  endfunction

  int          m_phase;
  logic [15:0] m_alu;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (do_reset) begin
      m_phase <= 0;
      m_alu   <= 16'd0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (m_phase == 2 && bus.instr[15])
        m_alu <= alu_model(bus.instr[14:12], bus.regval1, bus.regval2);
      m_phase <= (m_phase == 6) ? 0 : m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("strobes", {25'd0, strobes}, {25'd0, exp_strobes(m_phase, bus.instr, do_reset)});
      check("aluout", {16'd0, bus.aluout}, {16'd0, m_alu});
      check("fields", {16'd0, bus.opcode, bus.reg1, bus.reg2, bus.reg3}, {16'd0, bus.instr});
      check("imm", {20'd0, bus.bigval, bus.smallval}, {20'd0, bus.instr[7:0], bus.instr[3:0]});
      check("aluclass", {28'd0, bus.isaluop, bus.aluop}, {28'd0, bus.instr[15:12]});
      check("storeval", {16'd0, bus.storeval}, {16'd0, exp_store(bus.instr, bus.portin, m_alu)});
      check("pointer_adj", {16'd0, bus.pointer_adj}, {16'd0, exp_ptr(bus.instr, bus.regval1)});
    end
  end

  // ---------------- driver ----------------
  logic [6:0]  strobe_log [7];
  logic [15:0] alu_log [7];
  logic [3:0]  l_opcode, l_reg1, l_reg2, l_reg3;
  logic [7:0]  l_big;
  logic [15:0] l_store, l_ptr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [15:0] r1, input logic [15:0] r2,
                           input logic [15:0] pin);
    bus.instr   = ins;
    bus.regval1 = r1;
    bus.regval2 = r2;
    bus.portin  = pin;
    for (int p = 0; p < 7; p++) begin
      @(negedge clk);
      strobe_log[p] = strobes;
      alu_log[p]    = bus.aluout;
      if (p == 0) begin
        l_opcode = bus.opcode;
        l_reg1   = bus.reg1;
        l_reg2   = bus.reg2;
        l_reg3   = bus.reg3;
        l_big    = bus.bigval;
        l_store  = bus.storeval;
        l_ptr    = bus.pointer_adj;
      end
      step();
    end
  endtask

  initial begin
    do_reset    = 1'b1;
    bus.instr   = 16'h0000;
    bus.regval1 = 16'h0000;
    bus.regval2 = 16'h0000;
    bus.portin  = 16'h0000;
    step();
    step();
    @(negedge clk);
    check("rst_strobes", {25'd0, strobes}, 32'd0);
    check("rst_aluout", {16'd0, bus.aluout}, 32'd0);
    check("rst_state", {29'd0, bus.state}, {29'd0, ST_FETCH});
    step();
    do_reset = 1'b0;

    // LOADLO
    run_instr(16'h1234, 16'h0000, 16'h0000, 16'h0000);
    check("ld_opcode", {28'd0, l_opcode}, 32'd1);
    check("ld_reg1", {28'd0, l_reg1}, 32'd2);
    check("ld_reg2", {28'd0, l_reg2}, 32'd3);
    check("ld_reg3", {28'd0, l_reg3}, 32'd4);
    check("ld_bigval", {24'd0, l_big}, 32'h34);
    check("ld_storeval", {16'd0, l_store}, 32'h0034);
    check("ld_fetch_c1", {25'd0, strobe_log[0]}, 32'h01);
    check("ld_regstore_c6", {25'd0, strobe_log[5]}, 32'h20);
    check("ld_no_aluop", {25'd0, strobe_log[2]}, 32'h00);

    // ADD wraps
    run_instr(16'h8123, 16'hFFFF, 16'h0002, 16'h0000);
    check("add_before_edge", {16'd0, alu_log[2]}, 32'h0000);
    check("add_after_aluop", {16'd0, alu_log[3]}, 32'h0001);
    check("add_held_next", {16'd0, alu_log[6]}, 32'h0001);
    check("add_aluop_strobe", {25'd0, strobe_log[2]}, 32'h04);

    run_instr(16'hD000, 16'h0001, 16'h0004, 16'h0000);
    check("shl", {16'd0, alu_log[3]}, 32'h0010);
    run_instr(16'h9000, 16'h0003, 16'h0005, 16'h0000);
    check("sub_wrap", {16'd0, alu_log[3]}, 32'hFFFE);
    run_instr(16'hE000, 16'h8000, 16'h0013, 16'h0000);
    check("shr_logical", {16'd0, alu_log[3]}, 32'h1000);
    run_instr(16'hF000, 16'h0000, 16'h1234, 16'h0000);
    check("not", {16'd0, alu_log[3]}, 32'hFFFF);

    run_instr(16'h40FE, 16'h0000, 16'h0000, 16'h0000);
    check("jmp_ptr", {16'd0, l_ptr}, 32'hFFFE);
    check("jmp_no_regstore", {25'd0, strobe_log[5]}, 32'h00);
    run_instr(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    check("nop_ptr", {16'd0, l_ptr}, 32'h0001);
    run_instr(16'h5005, 16'h0000, 16'h0000, 16'h0000);
    check("br_zero_ptr", {16'd0, l_ptr}, 32'h0001);
    run_instr(16'h5005, 16'h0007, 16'h0000, 16'h0000);
`ifdef EXEC_BRANCH_EN
    check("br_taken_ptr", {16'd0, l_ptr}, 32'h0005);
`else
    check("br_disabled_ptr", {16'd0, l_ptr}, 32'h0001);
`endif

    run_instr(16'h2000, 16'h0000, 16'h0000, 16'hBEEF);
    check("in_storeval", {16'd0, l_store}, 32'hBEEF);
    check("in_memload", {25'd0, strobe_log[3]}, 32'h08);
    check("in_regstore", {25'd0, strobe_log[5]}, 32'h20);
    check("in_alu_kept", {16'd0, alu_log[6]}, 32'hFFFF);

    // reset asserted in the ALUOP phase of an ADD
    bus.instr   = 16'h8000;
    bus.regval1 = 16'h0001;
    bus.regval2 = 16'h0001;
    step();
    step();
    do_reset = 1'b1;
    @(negedge clk);
    check("midrst_strobes", {25'd0, strobes}, 32'd0);
    check("midrst_alu_hold", {16'd0, bus.aluout}, 32'hFFFF);
    step();
    @(negedge clk);
    check("midrst_next_strobes", {25'd0, strobes}, 32'd0);
    check("midrst_aluout", {16'd0, bus.aluout}, 32'h0000);
    step();
    do_reset = 1'b0;
    run_instr(16'h3000, 16'h0000, 16'h0000, 16'h0000);
    check("post_rst_fetch", {25'd0, strobe_log[0]}, 32'h01);
    check("out_memstore", {25'd0, strobe_log[4]}, 32'h10);
    check("out_quiet", {25'd0, strobe_log[2] | strobe_log[3] | strobe_log[5]}, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
